// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single byte-lane data-memory port between the CPU MEM stage and
// a VGA framebuffer fetcher. Each cycle at most one requester drives the
// memory port. The CPU is stalled on cycles where it is not granted. VGA
// bursts are issued one word per granted cycle and resume wherever they were
// interrupted. BRAM read data arrives one cycle after issue and is steered
// back to whichever requester issued the read.
//
// Build option:
//   MEMARB_STARVE_GUARD_EN  When defined, a pending VGA beat that has lost to
//                           the CPU STARVE_LIMIT consecutive times is forced
//                           through. When undefined, the CPU has strict
//                           priority, VGA beats issue only when cpu_req = 0,
//                           and STARVE_LIMIT has no effect on the logic.
//
// Parameters:
//   STARVE_LIMIT     consecutive CPU wins tolerated by a pending beat (1..15)
//   LEN_W            width of burst length and beat index
//
// Ports:
//   clk              system clock, rising edge
//   reset            synchronous, active-high; clears all state
//   cpu_req          CPU access valid this cycle
//   cpu_addr         CPU byte address
//   cpu_access_code  bit4 = store, bits3:0 = byte enables
//   cpu_wdata        CPU store data
//   cpu_gnt          CPU access issued to memory this cycle
//   cpu_stall        cpu_req & ~cpu_gnt
//   cpu_rdata        CPU load data (0 when cpu_rvalid = 0)
//   cpu_rvalid       cpu_rdata valid
//   vga_start        start-burst pulse (ignored while busy or when len = 0)
//   vga_base         burst base byte address
//   vga_len          burst length in words
//   vga_busy         burst active
//   vga_rdata        fetched word (0 when vga_rvalid = 0)
//   vga_rvalid       vga_rdata valid
//   vga_rindex       0-based beat index of vga_rdata
//   vga_done         one-cycle pulse coinciding with the final vga_rvalid
//   mem_addr         address to memory unit
//   mem_access_code  access code to memory unit (0 = no access)
//   mem_wdata        store data to memory unit
//   mem_rdata        memory read data, valid one cycle after issue
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int LEN_W        = 8
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             cpu_req,
  input  logic [31:0]      cpu_addr,
  input  logic [4:0]       cpu_access_code,
  input  logic [31:0]      cpu_wdata,
  output logic             cpu_gnt,
  output logic             cpu_stall,
  output logic [31:0]      cpu_rdata,
  output logic             cpu_rvalid,

  input  logic             vga_start,
  input  logic [31:0]      vga_base,
  input  logic [LEN_W-1:0] vga_len,
  output logic             vga_busy,
  output logic [31:0]      vga_rdata,
  output logic             vga_rvalid,
  output logic [LEN_W-1:0] vga_rindex,
  output logic             vga_done,

  output logic [31:0]      mem_addr,
  output logic [4:0]       mem_access_code,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata
);

  // An out-of-range limit would make the 4-bit starvation counter
  // meaningless, so refuse to elaborate.
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limit_check
    $error("mem_port_arbiter: STARVE_LIMIT must be in 1..15");
  end

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  // Who owns the read data returning next cycle.
  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_VGA
  } owner_t;

  localparam logic [4:0]       WORD_LOAD = 5'b01111;
  localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t           state_q,     state_d;
  logic [31:0]      beat_addr_q, beat_addr_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [LEN_W-1:0] issue_idx_q, issue_idx_d;

  // Read-return tag: owner, beat index, and whether it was the final beat.
  // Carrying a "last" flag with the tag makes vga_done independent of a
  // new burst being latched in the very cycle the final word returns.
  owner_t           owner_q,     owner_d;
  logic [LEN_W-1:0] ret_idx_q,   ret_idx_d;
  logic             ret_last_q,  ret_last_d;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic vga_pending;
  logic cpu_win;
  logic vga_win;

  assign vga_pending = (state_q == BURST) && (remaining_q != '0);

`ifdef MEMARB_STARVE_GUARD_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       force_vga;

  // Once the pending beat has lost LIMIT times in a row it takes the port
  // regardless of cpu_req.
  assign force_vga = vga_pending && (starve_cnt_q == LIMIT);
  assign cpu_win   = cpu_req && !force_vga;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if ((state_q == IDLE) || vga_win) begin
      starve_cnt_d = '0;
    end else if (vga_pending && cpu_win && (starve_cnt_q != LIMIT)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  // Strict CPU priority: VGA only uses cycles the CPU leaves idle.
  assign cpu_win = cpu_req;
`endif

  assign vga_win   = vga_pending && !cpu_win;
  assign cpu_gnt   = cpu_win;
  assign cpu_stall = cpu_req && !cpu_win;

  // ---------------------------------------------------------------------------
  // Next-state, port mux and return-tag capture
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the if/case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d         = state_q;
    beat_addr_d     = beat_addr_q;
    remaining_d     = remaining_q;
    issue_idx_d     = issue_idx_q;
    owner_d         = OWN_NONE;
    ret_idx_d       = ret_idx_q;
    ret_last_d      = 1'b0;
    mem_addr        = '0;
    mem_access_code = '0;
    mem_wdata       = '0;

    if (cpu_win) begin
      mem_addr        = cpu_addr;
      mem_access_code = cpu_access_code;
      mem_wdata       = cpu_wdata;
      // Stores produce no read data, so nothing should come back.
      owner_d         = cpu_access_code[4] ? OWN_NONE : OWN_CPU;
    end else if (vga_win) begin
      mem_addr        = beat_addr_q;
      mem_access_code = WORD_LOAD;
      owner_d         = OWN_VGA;
      ret_idx_d       = issue_idx_q;
      ret_last_d      = (remaining_q == LEN_ONE);
      beat_addr_d     = beat_addr_q + 32'd4;
      remaining_d     = remaining_q - LEN_ONE;
      issue_idx_d     = issue_idx_q + LEN_ONE;
    end

    unique case (state_q)
      IDLE: begin
        // vga_win is never set in IDLE, so latching here cannot collide
        // with the beat-advance updates above.
        if (vga_start && (vga_len != '0)) begin
          state_d     = BURST;
          beat_addr_d = vga_base;
          remaining_d = vga_len;
          issue_idx_d = '0;
        end
      end
      BURST: begin
        if (vga_win && (remaining_q == LEN_ONE)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples its pre-edge inputs regardless of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the datapath registers are reset too, not just the control
      // state, because vga_rindex is driven straight from ret_idx_q and has
      // a defined reset value.
      state_q     <= IDLE;
      beat_addr_q <= '0;
      remaining_q <= '0;
      issue_idx_q <= '0;
      owner_q     <= OWN_NONE;
      ret_idx_q   <= '0;
      ret_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_addr_q <= beat_addr_d;
      remaining_q <= remaining_d;
      issue_idx_q <= issue_idx_d;
      owner_q     <= owner_d;
      ret_idx_q   <= ret_idx_d;
      ret_last_q  <= ret_last_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read return: mem_rdata passes straight through to the tagged owner.
  // ---------------------------------------------------------------------------
  assign cpu_rvalid = (owner_q == OWN_CPU);
  assign vga_rvalid = (owner_q == OWN_VGA);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign vga_rdata  = vga_rvalid ? mem_rdata : '0;
  assign vga_rindex = ret_idx_q;
  // ret_last_q is equivalent to ret_idx_q == latched vga_len - 1.
  assign vga_done   = vga_rvalid && ret_last_q;
  assign vga_busy   = (state_q == BURST);

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter. A 64-word BRAM model answers the
// memory port. The reference model keeps an outstanding VGA burst as a queue
// of beats, decides the winner each cycle from the arbitration rules, and
// predicts the read return one cycle later. Directed scenarios are followed
// by randomized traffic.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int STARVE_LIMIT = 8;
  localparam int LEN_W        = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             cpu_req;
  logic [31:0]      cpu_addr;
  logic [4:0]       cpu_access_code;
  logic [31:0]      cpu_wdata;
  logic             cpu_gnt;
  logic             cpu_stall;
  logic [31:0]      cpu_rdata;
  logic             cpu_rvalid;
  logic             vga_start;
  logic [31:0]      vga_base;
  logic [LEN_W-1:0] vga_len;
  logic             vga_busy;
  logic [31:0]      vga_rdata;
  logic             vga_rvalid;
  logic [LEN_W-1:0] vga_rindex;
  logic             vga_done;
  logic [31:0]      mem_addr;
  logic [4:0]       mem_access_code;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .LEN_W       (LEN_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_req        (cpu_req),
    .cpu_addr       (cpu_addr),
    .cpu_access_code(cpu_access_code),
    .cpu_wdata      (cpu_wdata),
    .cpu_gnt        (cpu_gnt),
    .cpu_stall      (cpu_stall),
    .cpu_rdata      (cpu_rdata),
    .cpu_rvalid     (cpu_rvalid),
    .vga_start      (vga_start),
    .vga_base       (vga_base),
    .vga_len        (vga_len),
    .vga_busy       (vga_busy),
    .vga_rdata      (vga_rdata),
    .vga_rvalid     (vga_rvalid),
    .vga_rindex     (vga_rindex),
    .vga_done       (vga_done),
    .mem_addr       (mem_addr),
    .mem_access_code(mem_access_code),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata)
  );

  // ---------------------------------------------------------------------------
  // BRAM model: 64 words indexed by addr[7:2], byte-enabled writes,
  // read-before-write, one-cycle read latency.
  // ---------------------------------------------------------------------------
  logic [31:0] bram [64];
  bit          bram_ready = 1'b0;

  always @(posedge clk) begin
    if (!bram_ready) begin
      for (int i = 0; i < 64; i++) begin
        bram[i] <= (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
      end
      bram_ready <= 1'b1;
    end else if (mem_access_code[4]) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_access_code[b]) begin
          bram[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
    mem_rdata <= bram[mem_addr[7:2]];
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0]      addr;
    logic [LEN_W-1:0] idx;
    bit               last;
  } beat_t;

  typedef enum int { RET_NONE, RET_CPU, RET_VGA } ret_t;

  beat_t            beats[$];      // beats of the active burst not yet issued
  int               starve = 0;    // consecutive losses of the pending beat
  ret_t             ret_kind = RET_NONE;
  logic [31:0]      ret_data = '0;
  logic [LEN_W-1:0] ret_idx  = '0;
  bit               ret_last = 1'b0;

  // Called just after a negedge with inputs already driven. Checks this
  // cycle's outputs, then advances the model across the rising edge.
  task automatic cycle();
    bit          pend, force_v, cw, vw;
    logic [31:0] e_addr, e_wdata, e_data;
    logic [4:0]  e_code;

    #1;
    pend = (beats.size() != 0);
`ifdef MEMARB_STARVE_GUARD_EN
    force_v = pend && (starve == STARVE_LIMIT);
`else
    force_v = 1'b0;
`endif
    cw = cpu_req && !force_v;
    vw = pend && !cw;

    e_addr = '0; e_code = '0; e_wdata = '0; e_data = '0;
    if (cw) begin
      e_addr  = cpu_addr;
      e_code  = cpu_access_code;
      e_wdata = cpu_wdata;
      e_data  = bram[cpu_addr[7:2]];
    end else if (vw) begin
      e_addr  = beats[0].addr;
      e_code  = 5'b01111;
      e_data  = bram[beats[0].addr[7:2]];
    end

    check("cpu_gnt",    32'(cpu_gnt),         32'(cw));
    check("cpu_stall",  32'(cpu_stall),       32'(cpu_req && !cw));
    check("mem_addr",   mem_addr,             e_addr);
    check("mem_code",   32'(mem_access_code), 32'(e_code));
    check("mem_wdata",  mem_wdata,            e_wdata);
    check("vga_busy",   32'(vga_busy),        32'(pend));
    check("cpu_rvalid", 32'(cpu_rvalid),      32'(ret_kind == RET_CPU));
    check("cpu_rdata",  cpu_rdata,            (ret_kind == RET_CPU) ? ret_data : 32'h0);
    check("vga_rvalid", 32'(vga_rvalid),      32'(ret_kind == RET_VGA));
    check("vga_rdata",  vga_rdata,            (ret_kind == RET_VGA) ? ret_data : 32'h0);
    check("vga_done",   32'(vga_done),        32'(ret_kind == RET_VGA && ret_last));
    if (ret_kind == RET_VGA) begin
      check("vga_rindex", 32'(vga_rindex), 32'(ret_idx));
    end

    @(posedge clk);
    if (reset) begin
      beats.delete();
      starve   = 0;
      ret_kind = RET_NONE;
    end else begin
      if (cw) begin
        ret_kind = cpu_access_code[4] ? RET_NONE : RET_CPU;
        ret_data = e_data;
      end else if (vw) begin
        ret_kind = RET_VGA;
        ret_data = e_data;
        ret_idx  = beats[0].idx;
        ret_last = beats[0].last;
      end else begin
        ret_kind = RET_NONE;
      end

      if (!pend || vw) starve = 0;
      else if (cw && starve < STARVE_LIMIT) starve++;

      if (vw) void'(beats.pop_front());

      if (!pend && vga_start && (vga_len != '0)) begin
        for (int i = 0; i < int'(vga_len); i++) begin
          beat_t b;
          b.addr = vga_base + 32'(4 * i);
          b.idx  = LEN_W'(i);
          b.last = (i == int'(vga_len) - 1);
          beats.push_back(b);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic drive_idle();
    reset           = 1'b0;
    cpu_req         = 1'b0;
    cpu_addr        = '0;
    cpu_access_code = '0;
    cpu_wdata       = '0;
    vga_start       = 1'b0;
    vga_base        = '0;
    vga_len         = '0;
  endtask

  task automatic start_burst(input logic [31:0] base, input logic [LEN_W-1:0] len);
    vga_start = 1'b1;
    vga_base  = base;
    vga_len   = len;
  endtask

  task automatic cpu_load(input logic [31:0] addr);
    cpu_req         = 1'b1;
    cpu_addr        = addr;
    cpu_access_code = 5'b01111;
    cpu_wdata       = '0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    drive_idle();
    reset = 1'b1;
    @(negedge clk);
    repeat (3) cycle();
    reset = 1'b0;

    // Reset state.
    #1;
    check("rst_rindex", 32'(vga_rindex),      32'h0);
    check("rst_code",   32'(mem_access_code), 32'h0);
    check("rst_busy",   32'(vga_busy),        32'h0);
    cycle();

    // Idle CPU load at 0x10.
    cpu_load(32'h10);
    cycle();
    drive_idle();
    repeat (2) cycle();

    // Uncontested burst 0x100, len 4.
    start_burst(32'h100, LEN_W'(4));
    cycle();
    drive_idle();
    repeat (6) cycle();

    // CPU held high across a len-2 burst (starvation behaviour).
    start_burst(32'h40, LEN_W'(2));
    cpu_load(32'h20);
    cycle();
    vga_start = 1'b0;
    for (int i = 0; i < 24; i++) begin
      cpu_addr = $urandom & 32'hFC;
      cycle();
    end
    drive_idle();
    repeat (4) cycle();

    // CPU stores interleaved with VGA beats.
    start_burst(32'h80, LEN_W'(6));
    cycle();
    drive_idle();
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        cpu_req         = 1'b1;
        cpu_addr        = 32'h08;
        cpu_access_code = 5'b11111;
        cpu_wdata       = 32'hDEAD_BEEF;
      end else begin
        drive_idle();
      end
      cycle();
    end
    drive_idle();
    repeat (4) cycle();
    cpu_load(32'h08);
    cycle();
    drive_idle();
    #1;
    check("store_readback", cpu_rdata, 32'hDEAD_BEEF);
    cycle();

    // Zero-length start is ignored.
    start_burst(32'h200, LEN_W'(0));
    cycle();
    drive_idle();
    repeat (3) cycle();

    // Reset after 2 of 4 beats.
    start_burst(32'h100, LEN_W'(4));
    cycle();
    drive_idle();
    repeat (2) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    #1;
    check("midrst_rvalid", 32'(vga_rvalid), 32'h0);
    check("midrst_rindex", 32'(vga_rindex), 32'h0);
    check("midrst_busy",   32'(vga_busy),   32'h0);
    repeat (4) cycle();

    // Address wrap.
    start_burst(32'hFFFF_FFFC, LEN_W'(2));
    cycle();
    drive_idle();
    repeat (4) cycle();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      reset           = ($urandom_range(0, 499) == 0);
      cpu_req         = ($urandom_range(0, 99) < 55);
      cpu_addr        = $urandom;
      cpu_access_code = 5'($urandom);
      cpu_wdata       = $urandom;
      vga_start       = ($urandom_range(0, 7) == 0);
      vga_base        = $urandom & 32'hFFFF_FFFC;
      vga_len         = LEN_W'($urandom_range(0, 6));
      cycle();
    end
    drive_idle();
    repeat (30) cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single byte-lane data-memory port between the CPU MEM stage and a VGA framebuffer fetcher. It grants the memory port to one requester per cycle, stalls the CPU while the port is lent out, and sequences resumable VGA word bursts. It routes the one-cycle-late BRAM read data back to whichever requester issued the read. It sits between the EX/MEM pipeline register and the memory I/O unit.

## Interface
- STARVE_LIMIT, 8, consecutive cycles a pending VGA beat may lose to the CPU before VGA is forced through (1..15)
- LEN_W, 8, width of the burst length and beat index
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high; clears all state
- cpu_req  in  1  CPU memory access valid this cycle
- cpu_addr  in  32  CPU byte address
- cpu_access_code  in  5  bit4 = store, bits3:0 = byte enables
- cpu_wdata  in  32  CPU store data
- cpu_gnt  out  1  CPU access issued to memory this cycle
- cpu_stall  out  1  cpu_req & ~cpu_gnt
- cpu_rdata  out  32  load data
- cpu_rvalid  out  1  cpu_rdata valid
- vga_start  in  1  start-burst pulse
- vga_base  in  32  burst base byte address
- vga_len  in  LEN_W  burst length in words
- vga_busy  out  1  burst active
- vga_rdata  out  32  fetched word
- vga_rvalid  out  1  vga_rdata valid
- vga_rindex  out  LEN_W  beat index of vga_rdata, 0-based
- vga_done  out  1  one-cycle pulse with the final vga_rvalid
- mem_addr  out  32  to memory unit
- mem_access_code  out  5  to memory unit
- mem_wdata  out  32  to memory unit
- mem_rdata  in  32  memory read data, valid one cycle after issue

## Operation
- States: IDLE and BURST.
- IDLE -> BURST: on vga_start with vga_len != 0. On entry, latch beat_addr = vga_base, remaining = vga_len, issue_idx = 0.
- vga_start is ignored while in BURST, and when vga_len == 0 (no done pulse).
- BURST -> IDLE: the cycle the last beat issues (remaining becomes 0).
- Arbitration happens every cycle:
  - The VGA beat is pending when the state is BURST and remaining != 0.
  - The CPU wins if cpu_req is set, unless the VGA beat is pending and starve_cnt == STARVE_LIMIT.
  - Otherwise, a pending VGA beat wins.
- CPU win: mem_addr = cpu_addr, mem_access_code = cpu_access_code, mem_wdata = cpu_wdata, cpu_gnt = 1.
- VGA win: mem_addr = beat_addr, mem_access_code = 5'b01111 (word load), mem_wdata = 0. Then beat_addr += 4 (modulo 2^32), remaining -= 1, issue_idx += 1.
- No winner: mem_addr = 0, mem_access_code = 0, mem_wdata = 0.
- starve_cnt:
  - Increments when the VGA beat is pending and the CPU wins.
  - Clears when a VGA beat issues or the state is IDLE.
  - Saturates at STARVE_LIMIT.
- Read return:
  - A registered owner tag (none / cpu / vga) and the beat index are captured at issue.
  - A CPU store sets the tag to none.
  - The next cycle, mem_rdata is routed to cpu_rdata or vga_rdata and the matching rvalid is raised.
- vga_done = vga_rvalid & (returned index == latched vga_len - 1).

## Timing
- mem_* and cpu_gnt/cpu_stall are combinational from the current inputs and state, with no added latency.
- Read data latency: rvalid is high exactly 1 cycle after the grant cycle; rdata is mem_rdata passed through combinationally in that cycle.
- The first VGA beat can issue no earlier than the cycle after vga_start.
- A CPU request and a burst start in the same cycle: the CPU is granted, and the burst is latched.
- Back-to-back grants are allowed every cycle; there are no bubbles between requesters.
- Reset values:
  - state IDLE; starve_cnt 0; owner tag none.
  - cpu_rvalid, vga_rvalid, vga_done, vga_busy, vga_rindex, cpu_rdata and vga_rdata all 0.
  - mem_access_code 0 whenever cpu_req = 0 and no burst is active.
- Reset mid-burst aborts the burst. No done pulse is produced, and read data in flight is dropped (rvalid stays 0 the cycle after reset).

## Configuration
- MEMARB_STARVE_GUARD_EN defined: the starvation counter and forced VGA grant operate as above.
- MEMARB_STARVE_GUARD_EN undefined: strict CPU priority, and VGA beats issue only on cycles with cpu_req = 0. There is no starve_cnt register, and STARVE_LIMIT is unused.

## Test plan
- Idle CPU traffic: cpu_req with addr 0x10 and code 5'b01111 → cpu_gnt = 1 and cpu_stall = 0 the same cycle; cpu_rvalid with the BRAM word at 0x10 one cycle later; vga_rvalid stays 0.
- Uncontested burst: vga_start with base 0x100, len 4, cpu_req = 0 → mem_addr 0x100, 0x104, 0x108, 0x10C on consecutive cycles; vga_rindex 0..3; vga_done with index 3; vga_busy falls after the last issue.
- Starvation with guard enabled, STARVE_LIMIT = 8: cpu_req held high during a len-2 burst → 8 CPU grants, then 1 VGA grant with cpu_stall = 1 for that cycle, repeated. vga_done arrives after 18 issue cycles.
- Same stimulus with the guard disabled → no VGA beat issues until cpu_req drops; the burst then completes in 2 cycles.
- CPU store during a burst: store 0xDEADBEEF, code 5'b11111, to 0x08, interleaved with VGA beats → the store reaches memory with the correct code; no cpu_rvalid; later VGA data is unaffected.
- Edge cases:
  - vga_len = 0 → no state change and no done.
  - Reset asserted after 2 of 4 beats → outputs at reset values the next cycle; no further vga_rvalid.
  - Base 0xFFFFFFFC, len 2 → second beat address wraps to 0x00000000.
